// File: rtl/slot_pkg.sv
// Shared definitions for the slot machine reel controller:
// FSM state encoding and win score codes.
package slot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPIN = 2'd1,
    ST_EVAL = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE    = 2'd0;
  localparam logic [1:0] WIN_PAIR    = 2'd1;
  localparam logic [1:0] WIN_TRIPLE  = 2'd2;
  localparam logic [1:0] WIN_JACKPOT = 2'd3;

endpackage

// File: rtl/reel_counter.sv
// One reel: symbol register plus its remaining-step down-counter.
// Steps once per tick until the counter reaches zero, then holds.
module reel_counter #(
  parameter int SYM_W = 3,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] count_in,
  input  logic             tick,
  input  logic             hold,
  output logic [SYM_W-1:0] sym,
  output logic [CNT_W-1:0] remaining
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym       <= '0;
      remaining <= '0;
    end else if (load) begin
      remaining <= count_in;
    end else if (tick && !hold && (remaining != '0)) begin
      sym       <= sym + SYM_W'(1);
      remaining <= remaining - CNT_W'(1);
    end
  end

endmodule

// File: rtl/reel_spinner.sv
// Three-reel spin controller: seeds stop counts from the LFSR, steps the
// reels at a prescaled rate, then scores the final symbols.
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | waiting for start; reels and win hold last result
// SPIN    | prescaler running, reels stepping on each tick
// EVAL    | one cycle: score reels, pulse done on exit
module reel_spinner
  import slot_pkg::*;
#(
  parameter int LFSR_WIDTH  = 10,
  parameter int NUM_SYMBOLS = 8,
  parameter int MIN_SPIN    = 8,
  parameter int STEP_DIV    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [LFSR_WIDTH-1:0]          lfsr_in,
  input  logic                           start,
  output logic                           busy,
  output logic [$clog2(NUM_SYMBOLS)-1:0] reel0,
  output logic [$clog2(NUM_SYMBOLS)-1:0] reel1,
  output logic [$clog2(NUM_SYMBOLS)-1:0] reel2,
  output logic                           done,
  output logic [1:0]                     win
);

  localparam int SYM_W = $clog2(NUM_SYMBOLS);
  localparam int CNT_W = $clog2(3 * MIN_SPIN + NUM_SYMBOLS);
  localparam int PRE_W = $clog2(STEP_DIV);

  state_t             state, state_next;
  logic [PRE_W-1:0]   prescaler;
  logic               load;
  logic               tick;
  logic [1:0]         win_score;
  logic [SYM_W-1:0]   sym [3];
  logic [CNT_W-1:0]   rem [3];

  // Bits above the three fields carry no information for the stop counts.
  logic unused_seed_bits;
  assign unused_seed_bits = ^lfsr_in;

  assign tick = (state == ST_SPIN) && (prescaler == PRE_W'(STEP_DIV - 1));

  for (genvar k = 0; k < 3; k++) begin : g_reel
    logic [CNT_W-1:0] count_in;
    assign count_in = CNT_W'(MIN_SPIN * (k + 1)) + CNT_W'(lfsr_in[SYM_W*k +: SYM_W]);

    reel_counter #(
      .SYM_W (SYM_W),
      .CNT_W (CNT_W)
    ) u_reel (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .count_in  (count_in),
      .tick      (tick),
      .hold      (state != ST_SPIN),
      .sym       (sym[k]),
      .remaining (rem[k])
    );
  end

  assign reel0 = sym[0];
  assign reel1 = sym[1];
  assign reel2 = sym[2];
  assign busy  = (state == ST_SPIN) || (state == ST_EVAL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Reel 2 always stops last, so its final step ends the spin.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SPIN;
          load       = 1'b1;
        end
      end
      ST_SPIN: begin
        if (tick && (rem[2] == CNT_W'(1))) state_next = ST_EVAL;
      end
      ST_EVAL: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    win_score = WIN_NONE;
    if ((sym[0] == sym[1]) && (sym[1] == sym[2])) begin
      win_score = (sym[0] == {SYM_W{1'b1}}) ? WIN_JACKPOT : WIN_TRIPLE;
    end else if ((sym[0] == sym[1]) || (sym[1] == sym[2]) || (sym[0] == sym[2])) begin
      win_score = WIN_PAIR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      win       <= WIN_NONE;
      done      <= 1'b0;
    end else begin
      done <= (state == ST_EVAL);
      if (load) begin
        prescaler <= '0;
        win       <= WIN_NONE;
      end else begin
        if (state == ST_SPIN) prescaler <= tick ? '0 : prescaler + PRE_W'(1);
        if (state == ST_EVAL) win <= win_score;
      end
    end
  end

endmodule
